// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin
//  Description : Converts five BCD digits to a 16-bit binary value, one
//                multiply-by-10-and-add step per clock, with start/busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ten_thous,
    input  logic [3:0]  thousands,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  tens,
    input  logic [3:0]  ones,
    output logic [15:0] numb,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'd4;

    state_t      state_q, state_d;
    logic [19:0] dig_q,   dig_d;
    logic [16:0] acc_q,   acc_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic        bad_q,   bad_d;
    logic [15:0] numb_q,  numb_d;
    logic        err_q,   err_d;
    logic        done_q,  done_d;
    logic [16:0] acc_next;

    // Current digit sits in the top nibble of the shift register.
    assign acc_next = (acc_q << 3) + (acc_q << 1) + {13'd0, dig_q[19:16]};

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        numb_d  = numb_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dig_d   = {ten_thous, thousands, hundreds, tens, ones};
                    acc_d   = 17'd0;
                    cnt_d   = 3'd0;
                    bad_d   = (ten_thous > 4'd9) || (thousands > 4'd9) ||
                              (hundreds  > 4'd9) || (tens      > 4'd9) ||
                              (ones      > 4'd9);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = acc_next;
                dig_d = {dig_q[15:0], 4'h0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    done_d  = 1'b1;
                    // Invalid digits take priority over overflow saturation.
                    if (bad_q) begin
                        numb_d = 16'h0000;
                        err_d  = 1'b1;
                    end else if (acc_next[16]) begin
                        numb_d = 16'hFFFF;
                        err_d  = 1'b1;
                    end else begin
                        numb_d = acc_next[15:0];
                        err_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dig_q   <= 20'd0;
            acc_q   <= 17'd0;
            cnt_q   <= 3'd0;
            bad_q   <= 1'b0;
            numb_q  <= 16'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            numb_q  <= numb_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign numb = numb_q;
    assign busy = (state_q == S_CONV);
    assign done = done_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin
//  Description : Self-checking bench for bcd_to_bin against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ten_thous, thousands, hundreds, tens, ones;
    logic [15:0] numb;
    logic        busy, done, err;

    int n_cmp  = 0;
    int n_fail = 0;

    bcd_to_bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ten_thous (ten_thous),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .numb      (numb),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {err, numb} computed from the decimal weights of the digits.
    function automatic logic [16:0] ref_model(input logic [19:0] v);
        int  w [5] = '{1, 10, 100, 1000, 10000};
        int  val   = 0;
        bit  bad   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int d;
            d = int'(v[i*4 +: 4]);
            if (d > 9) bad = 1'b1;
            val += d * w[i];
        end
        if (bad)              return {1'b1, 16'h0000};
        else if (val > 65535) return {1'b1, 16'hFFFF};
        else                  return {1'b0, val[15:0]};
    endfunction

    task automatic set_digits(input logic [19:0] v);
        ten_thous = v[19:16];
        thousands = v[15:12];
        hundreds  = v[11:8];
        tens      = v[7:4];
        ones      = v[3:0];
    endtask

    // Presents digits with start for one edge, then scrambles the inputs.
    task automatic launch(input logic [19:0] v);
        set_digits(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        set_digits(20'($urandom));
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if (numb !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: numb=%h busy=%b done=%b err=%b required 0000/0/0/0",
                     numb, busy, done, err);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_conversions;
        logic [19:0] vecs[$];
        logic [16:0] exp;
        logic [19:0] v;
        vecs = '{20'h12345, 20'h00000, 20'h65535, 20'h65536, 20'h99999,
                 20'h000A0, 20'h00042, 20'h99990, 20'h00F00};
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 5; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) v[19:16] = 4'd6;
            if ($urandom_range(0, 7) == 0)
                v[$urandom_range(0, 4)*4 +: 4] = 4'($urandom_range(10, 15));
            vecs.push_back(v);
        end
        foreach (vecs[j]) begin
            exp = ref_model(vecs[j]);
            launch(vecs[j]);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL conv_busy_start vec=%h: busy=%b required 1", vecs[j], busy);
            end
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk); #1;
                n_cmp++;
                if (k < 5) begin
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL conv_progress vec=%h cyc=%0d: busy=%b done=%b required 1/0",
                                 vecs[j], k, busy, done);
                    end
                end else if (busy !== 1'b0 || done !== 1'b1 || numb !== exp[15:0] || err !== exp[16]) begin
                    n_fail++;
                    $display("FAIL conv_result vec=%h: busy=%b done=%b numb=%h err=%b required 0/1/%h/%b",
                             vecs[j], busy, done, numb, err, exp[15:0], exp[16]);
                end
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || numb !== exp[15:0] || err !== exp[16]) begin
                n_fail++;
                $display("FAIL conv_hold vec=%h: done=%b busy=%b numb=%h err=%b required 0/0/%h/%b",
                         vecs[j], done, busy, numb, err, exp[15:0], exp[16]);
            end
        end
    endtask

    task automatic test_ignore_start;
        launch(20'h12345);
        @(posedge clk); #1;
        set_digits(20'h99999);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b1 || numb !== 16'h3039 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: done=%b numb=%h err=%b required 1/3039/0", done, numb, err);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || numb !== 16'h3039) begin
                n_fail++;
                $display("FAIL ignore_no_second cyc=%0d: done=%b busy=%b numb=%h required 0/0/3039",
                         k, done, busy, numb);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_busy, exp_done;
        set_digits(20'h00255);
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            exp_done = (k == 5) || (k == 11);
            exp_busy = !exp_done;
            n_cmp++;
            if (busy !== exp_busy || done !== exp_done || (busy === 1'b1 && done === 1'b1)) begin
                n_fail++;
                $display("FAIL b2b_handshake cyc=%0d: busy=%b done=%b required %b/%b",
                         k, busy, done, exp_busy, exp_done);
            end
            if (exp_done) begin
                n_cmp++;
                if (numb !== 16'd255 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result cyc=%0d: numb=%h err=%b required 00ff/0", k, numb, err);
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        launch(20'h99999);
        repeat (6) @(posedge clk);
        #1;
        launch(20'h12345);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (numb !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: numb=%h busy=%b done=%b err=%b required 0000/0/0/0",
                     numb, busy, done, err);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cyc=%0d: done=%b busy=%b required 0/0", k, done, busy);
            end
        end
        launch(20'h00007);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || numb !== 16'd7 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: done=%b numb=%h err=%b required 1/0007/0", done, numb, err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_digits(20'h00000);
        test_reset();
        test_conversions();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
